// File: rtl/fmab_lanes.sv
// Multi-lane bf16 dot-product engine with block-floating accumulators.
// Two stages (operand product, accumulate) with group framing and a held output register.
module fmab_lanes #(
    parameter int LANES = 4,
    parameter int GUARD = 8,
    parameter int ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [16*LANES-1:0]      in_a,
    input  logic [16*LANES-1:0]      in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W*LANES-1:0]   out_acc,
    output logic [10*LANES-1:0]      out_exp,
    output logic [LANES-1:0]         out_ovf
);

    // Arithmetic right shift where any distance of ACC_W or more collapses to the sign fill.
    function automatic logic [ACC_W-1:0] sra_fill(input logic [ACC_W-1:0] x, input logic [9:0] amt);
        logic [ACC_W-1:0] r;
        if (amt >= 10'(ACC_W)) begin
            r = {ACC_W{x[ACC_W-1]}};
        end else begin
            r = $signed(x) >>> amt;
        end
        return r;
    endfunction

    // Saturating signed add; bit ACC_W of the result flags saturation.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        logic [ACC_W:0]   r;
        s = a + b;
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            r = a[ACC_W-1] ? {2'b11, {(ACC_W-1){1'b0}}} : {2'b10, {(ACC_W-1){1'b1}}};
        end else begin
            r = {1'b0, s};
        end
        return r;
    endfunction

    logic                          r_s1_valid;
    logic                          r_s1_last;
    logic [LANES-1:0][15:0]        r_s1_p;
    logic [LANES-1:0][9:0]         r_s1_pe;
    logic [LANES-1:0]              r_s1_s;
    logic [LANES-1:0]              r_s1_z;

    logic [LANES-1:0][ACC_W-1:0]   r_acc;
    logic [LANES-1:0][9:0]         r_exp;
    logic [LANES-1:0]              r_empty;
    logic [LANES-1:0]              r_ovf;

    logic                          r_out_valid;
    logic [LANES-1:0][ACC_W-1:0]   r_out_acc;
    logic [LANES-1:0][9:0]         r_out_exp;
    logic [LANES-1:0]              r_out_ovf;

    logic [LANES-1:0][15:0]        w_p;
    logic [LANES-1:0][9:0]         w_pe;
    logic [LANES-1:0]              w_s;
    logic [LANES-1:0]              w_z;
    logic [LANES-1:0][ACC_W-1:0]   w_pmag;
    logic [LANES-1:0][ACC_W-1:0]   w_prod;
    logic [LANES-1:0][ACC_W:0]     w_sum;
    logic [LANES-1:0][ACC_W-1:0]   w_acc_nx;
    logic [LANES-1:0][9:0]         w_exp_nx;
    logic [LANES-1:0]              w_empty_nx;
    logic [LANES-1:0]              w_ovf_nx;
    logic                          w_s2_fire;
    logic                          w_accept;

    // A pending last beat may not overwrite an unconsumed result.
    assign w_s2_fire = r_s1_valid & ~(r_s1_last & r_out_valid & ~out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_fire;
    assign w_accept  = in_valid & in_ready;

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_exp   = r_out_exp;
    assign out_ovf   = r_out_ovf;

    // Stage 1 operand decode: mantissa product, exponent sum, sign and zero detect per lane.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_p[i]  = 16'({1'b1, in_a[16*i +: 7]}) * 16'({1'b1, in_b[16*i +: 7]});
            w_pe[i] = 10'(in_a[16*i+7 +: 8]) + 10'(in_b[16*i+7 +: 8]);
            w_s[i]  = in_a[16*i+15] ^ in_b[16*i+15];
            w_z[i]  = (in_a[16*i+7 +: 8] == 8'd0) | (in_b[16*i+7 +: 8] == 8'd0);
        end
    end

    // Stage 2 next lane state: align the smaller-exponent operand, then saturating add.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_pmag[i]     = {{(ACC_W-16-GUARD){1'b0}}, r_s1_p[i], {GUARD{1'b0}}};
            w_prod[i]     = r_s1_s[i] ? (~w_pmag[i] + {{(ACC_W-1){1'b0}}, 1'b1}) : w_pmag[i];
            w_sum[i]      = '0;
            w_acc_nx[i]   = r_acc[i];
            w_exp_nx[i]   = r_exp[i];
            w_empty_nx[i] = r_empty[i];
            w_ovf_nx[i]   = r_ovf[i];
            if (r_s1_z[i]) begin
                w_sum[i] = '0;
            end else if (r_empty[i]) begin
                w_acc_nx[i]   = w_prod[i];
                w_exp_nx[i]   = r_s1_pe[i];
                w_empty_nx[i] = 1'b0;
            end else if (r_s1_pe[i] > r_exp[i]) begin
                w_sum[i]    = sat_add(sra_fill(r_acc[i], r_s1_pe[i] - r_exp[i]), w_prod[i]);
                w_acc_nx[i] = w_sum[i][ACC_W-1:0];
                w_exp_nx[i] = r_s1_pe[i];
                w_ovf_nx[i] = r_ovf[i] | w_sum[i][ACC_W];
            end else begin
                w_sum[i]    = sat_add(r_acc[i], sra_fill(w_prod[i], r_exp[i] - r_s1_pe[i]));
                w_acc_nx[i] = w_sum[i][ACC_W-1:0];
                w_ovf_nx[i] = r_ovf[i] | w_sum[i][ACC_W];
            end
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_p     <= '0;
            r_s1_pe    <= '0;
            r_s1_s     <= '0;
            r_s1_z     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= in_last;
            r_s1_p     <= w_p;
            r_s1_pe    <= w_pe;
            r_s1_s     <= w_s;
            r_s1_z     <= w_z;
        end else if (w_s2_fire) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Lane accumulator state; a last beat hands the result off and restarts every lane empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_exp   <= '0;
            r_empty <= '1;
            r_ovf   <= '0;
        end else if (w_s2_fire && r_s1_last) begin
            r_acc   <= '0;
            r_exp   <= '0;
            r_empty <= '1;
            r_ovf   <= '0;
        end else if (w_s2_fire) begin
            r_acc   <= w_acc_nx;
            r_exp   <= w_exp_nx;
            r_empty <= w_empty_nx;
            r_ovf   <= w_ovf_nx;
        end else begin
            r_acc   <= r_acc;
        end
    end

    // Output register: loads on group end, otherwise holds until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_exp   <= '0;
            r_out_ovf   <= '0;
        end else if (w_s2_fire && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_acc   <= w_acc_nx;
            r_out_exp   <= w_exp_nx;
            r_out_ovf   <= w_ovf_nx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

endmodule

// File: tb/tb_fmab_lanes.sv
// Directed-vector bench for fmab_lanes: a scoreboard queue is filled by the stimulus
// and drained by a monitor on every output handshake.
module tb_fmab_lanes;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_acc;
    logic [39:0]  out_exp;
    logic [3:0]   out_ovf;

    typedef struct packed {
        logic [127:0] acc;
        logic [39:0]  exp;
        logic [3:0]   ovf;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;

    fmab_lanes #(.LANES(4), .GUARD(8), .ACC_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_exp(out_exp), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] v4(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] a4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [39:0] e4(input logic [9:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic expect_res(input logic [127:0] acc, input logic [39:0] exp, input logic [3:0] ovf);
        res_t r;
        r.acc = acc; r.exp = exp; r.ovf = ovf;
        q.push_back(r);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_accept timed out waiting for in_ready");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && q.size() != 0; n++) @(negedge clk);
        check("drain_queue_empty", 128'(q.size()), 128'd0);
    endtask

    // Monitor: compares each handshaked result with the scoreboard and checks held data stays stable.
    bit   hold = 1'b0;
    res_t held;
    always @(negedge clk) begin
        res_t got, exp_r;
        #2;
        got.acc = out_acc; got.exp = out_exp; got.ovf = out_ovf;
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("held_valid", 128'(out_valid), 128'd1);
                check("held_data", 128'(got), 128'(held));
            end
            if (out_valid && out_ready) begin
                hold = 1'b0;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result actual=%h required=none", got);
                end else begin
                    exp_r = q.pop_front();
                    check("acc", got.acc, exp_r.acc);
                    check("exp", 128'(got.exp), 128'(exp_r.exp));
                    check("ovf", 128'(got.ovf), 128'(exp_r.ovf));
                end
            end else if (out_valid) begin
                hold = 1'b1;
                held = got;
            end else begin
                hold = 1'b0;
            end
        end
    end

    localparam logic [15:0] ONE  = 16'h3F80;
    localparam logic [15:0] MONE = 16'hBF80;
    localparam logic [15:0] TWO  = 16'h4000;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_acc", out_acc, 128'd0);
        check("rst_out_exp", 128'(out_exp), 128'd0);
        check("rst_out_ovf", 128'(out_ovf), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // single beat, with latency check
        expect_res(a4(32'h00400000, 0, 0, 0), e4(254, 0, 0, 0), 4'b0000);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);
        @(negedge clk); #1;
        check("latency_t1", 128'(out_valid), 128'd0);
        @(negedge clk); #1;
        check("latency_t2", 128'(out_valid), 128'd1);
        drain();

        // larger exponent later: accumulator shifted; then reversed order
        expect_res(a4(32'h00600000, 0, 0, 0), e4(255, 0, 0, 0), 4'b0000);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b0);
        beat(v4(TWO, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);
        expect_res(a4(32'h00600000, 0, 0, 0), e4(255, 0, 0, 0), 4'b0000);
        beat(v4(TWO, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b0);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);

        // cancellation, and zero lane
        expect_res(a4(32'h0, 0, 0, 0), e4(254, 0, 0, 0), 4'b0000);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b0);
        beat(v4(ONE, 0, 0, 0), v4(MONE, 0, 0, 0), 1'b1);

        // all lanes busy: lane3 = -2.0 * 1.5
        expect_res(a4(32'h00400000, 32'h00400000, 32'h00400000, 32'hFFA00000),
                   e4(254, 254, 254, 255), 4'b0000);
        beat(v4(ONE, ONE, ONE, 16'hC000), v4(ONE, ONE, ONE, 16'h3FC0), 1'b1);

        // boundaries: shift >= ACC_W (positive and negative fill), denormal flush, exponent 255
        expect_res(a4(32'h00400000, 32'h003FFFFF, 32'h0, 32'h00800000),
                   e4(254, 254, 0, 382), 4'b0000);
        beat(v4(16'h0080, 16'h8080, 16'h0040, 16'h7F80), v4(16'h0080, 16'h0080, ONE, ONE), 1'b0);
        beat(v4(ONE, ONE, 16'h0040, 16'h7F80), v4(ONE, ONE, ONE, ONE), 1'b1);
        drain();

        // saturation after 512 beats, then ovf clears for the next group
        expect_res(a4(32'h7FFFFFFF, 0, 0, 0), e4(254, 0, 0, 0), 4'b0001);
        for (int k = 0; k < 511; k++) beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b0);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);
        expect_res(a4(32'h00400000, 0, 0, 0), e4(254, 0, 0, 0), 4'b0000);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);
        drain();

        // backpressure: four single-beat groups with out_ready low, then one-cycle releases
        expect_res(a4(32'h00400000, 0, 0, 0), e4(254, 0, 0, 0), 4'b0000);
        expect_res(a4(32'h00400000, 0, 0, 0), e4(255, 0, 0, 0), 4'b0000);
        expect_res(a4(32'h00600000, 0, 0, 0), e4(255, 0, 0, 0), 4'b0000);
        expect_res(a4(32'h00400000, 0, 0, 0), e4(256, 0, 0, 0), 4'b0000);
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);
                beat(v4(ONE, 0, 0, 0), v4(TWO, 0, 0, 0), 1'b1);
                beat(v4(ONE, 0, 0, 0), v4(16'h4040, 0, 0, 0), 1'b1);
                beat(v4(ONE, 0, 0, 0), v4(16'h4080, 0, 0, 0), 1'b1);
            end
            begin
                repeat (12) @(negedge clk);
                #1;
                check("stall_in_ready", 128'(in_ready), 128'd0);
                check("stall_queue_held", 128'(q.size()), 128'd4);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk); out_ready = 1'b1;
                    @(negedge clk); out_ready = 1'b0;
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset mid-group discards the partial sums
        beat(v4(TWO, TWO, 0, 0), v4(ONE, ONE, 0, 0), 1'b0);
        beat(v4(TWO, TWO, 0, 0), v4(ONE, ONE, 0, 0), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        expect_res(a4(32'h00400000, 0, 0, 0), e4(254, 0, 0, 0), 4'b0000);
        beat(v4(ONE, 0, 0, 0), v4(ONE, 0, 0, 0), 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
